virt_mode_ctrl: RTL and testbench

- Clocked, parametrised virtual-mode controller for the Nabu MegaMapper CPLD.
- Tracks whether the Z80 runs a guest in virtual mode.
- Converts enabled trap sources and, optionally, guest IRQs into a supervisor NMI, then forces the supervisor's vector fetch through override_address.
- Latches trap cause and sticky pending bits for the supervisor; re-enters virtual mode after the supervisor's final return jump.

---
 rtl/virt_pkg.sv | 19 +
 rtl/trap_prio_enc.sv | 21 ++
 rtl/virt_mode_ctrl.sv | 157 +++++++++++++++
 tb/tb_virt_mode_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/virt_pkg.sv
// Shared types for the Nabu MegaMapper virtual-mode controller.
package virt_pkg;

    typedef enum logic [2:0] {
        NATIVE   = 3'd0,
        ARM      = 3'd1,
        VIRTUAL  = 3'd2,
        NMI      = 3'd3,
        WAIT_ACK = 3'd4,
        OVR      = 3'd5
    } virt_state_t;

    // Cause code reported for a guest IRQ in the default 4-source build
    // (the IRQ always sits one index above the last trap source).
    localparam int DEF_NUM_TRAP = 4;
    localparam int DEF_CAUSE_W  = 3;
    localparam logic [DEF_CAUSE_W-1:0] IRQ_CAUSE = DEF_CAUSE_W'(DEF_NUM_TRAP);

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-wins priority encoder for trap requests; combinational.
module trap_prio_enc #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/virt_mode_ctrl.sv
// Virtual-mode controller: tracks guest execution, raises supervisor NMI on
// traps, and overrides the address map for the supervisor's vector fetch.
module virt_mode_ctrl
    import virt_pkg::*;
#(
    parameter int NUM_TRAP  = 4,
    parameter int CAUSE_W   = 3,
    parameter int NMI_PULSE = 4,
    parameter int OVR_M1    = 1,
    parameter int IRQ_TRAP  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m1_n,
    input  logic                irq_n,
    input  logic [NUM_TRAP-1:0] trap_req,
    input  logic [NUM_TRAP-1:0] trap_en,
    input  logic                enter_virtual,
    input  logic                new_isr,
    input  logic                last_isr_jmp,
    input  logic                clear_cause,
    output logic                virtual_mode,
    output logic                nmi_n,
    output logic                override_address,
    output logic [CAUSE_W-1:0]  trap_cause,
    output logic                trap_valid,
    output logic [NUM_TRAP:0]   trap_pending
);

    virt_state_t          state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 m1_q;
    logic                 virtual_mode_q, virtual_mode_d;
    logic                 nmi_n_q, nmi_n_d;
    logic                 override_q, override_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 valid_q, valid_d;
    logic [NUM_TRAP:0]    pending_q, pending_d;

    logic                 m1_end;
    logic                 irq_req;
    logic [NUM_TRAP:0]    req;
    logic [CAUSE_W-1:0]   enc_idx;
    logic                 enc_any;

    assign m1_end  = ~m1_q & m1_n;
    assign irq_req = (IRQ_TRAP != 0) & ~irq_n;
    assign req     = {irq_req, trap_req & trap_en};

    trap_prio_enc #(
        .N (NUM_TRAP + 1),
        .W (CAUSE_W)
    ) u_prio (
        .req (req),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        virtual_mode_d = virtual_mode_q;
        nmi_n_d        = nmi_n_q;
        override_d     = override_q;
        cause_d        = cause_q;
        valid_d        = valid_q & ~clear_cause;
        // A request seen in the same cycle as clear_cause survives the clear.
        pending_d      = (clear_cause ? '0 : pending_q) | (virtual_mode_q ? req : '0);

        case (state_q)
            NATIVE: begin
                if (enter_virtual) state_d = ARM;
            end
            ARM: begin
                if (m1_end && last_isr_jmp) begin
                    state_d        = VIRTUAL;
                    virtual_mode_d = 1'b1;
                end
            end
            VIRTUAL: begin
                if (enc_any) begin
                    cause_d = enc_idx;
                    valid_d = 1'b1;
                    nmi_n_d = 1'b0;
                    cnt_d   = 8'(NMI_PULSE - 1);
                    state_d = NMI;
                end
            end
            NMI: begin
                if (new_isr) begin
                    virtual_mode_d = 1'b0;
                    override_d     = 1'b1;
                    nmi_n_d        = 1'b1;
                    cnt_d          = 8'(OVR_M1);
                    state_d        = OVR;
                end else if (cnt_q == 8'd0) begin
                    nmi_n_d = 1'b1;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_ACK: begin
                if (new_isr) begin
                    virtual_mode_d = 1'b0;
                    override_d     = 1'b1;
                    cnt_d          = 8'(OVR_M1);
                    state_d        = OVR;
                end
            end
            OVR: begin
                if (m1_end) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d      = 8'd0;
                        override_d = 1'b0;
                        state_d    = NATIVE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = NATIVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= NATIVE;
            cnt_q          <= 8'd0;
            m1_q           <= 1'b1;
            virtual_mode_q <= 1'b0;
            nmi_n_q        <= 1'b1;
            override_q     <= 1'b0;
            cause_q        <= '0;
            valid_q        <= 1'b0;
            pending_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            m1_q           <= m1_n;
            virtual_mode_q <= virtual_mode_d;
            nmi_n_q        <= nmi_n_d;
            override_q     <= override_d;
            cause_q        <= cause_d;
            valid_q        <= valid_d;
            pending_q      <= pending_d;
        end
    end

    assign virtual_mode     = virtual_mode_q;
    assign nmi_n            = nmi_n_q;
    assign override_address = override_q;
    assign trap_cause       = cause_q;
    assign trap_valid       = valid_q;
    assign trap_pending     = pending_q;

endmodule

// File: tb/tb_virt_mode_ctrl.sv
// Directed-vector bench for virt_mode_ctrl: default build, IRQ_TRAP=0 build
// and OVR_M1=2 build driven from the same stimulus.
module tb_virt_mode_ctrl;
    import virt_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       m1_n, irq_n, enter_virtual, new_isr, last_isr_jmp, clear_cause;
    logic [3:0] trap_req, trap_en;

    logic       vm0, nmi0, ovr0, valid0;
    logic [2:0] cause0;
    logic [4:0] pend0;
    logic       vm1, nmi1, ovr1, valid1;
    logic [2:0] cause1;
    logic [4:0] pend1;
    logic       vm2, nmi2, ovr2, valid2;
    logic [2:0] cause2;
    logic [4:0] pend2;

    int n_vec  = 0;
    int n_miss = 0;
    logic seen;

    always #5 clk = ~clk;

    virt_mode_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .irq_n(irq_n),
        .trap_req(trap_req), .trap_en(trap_en), .enter_virtual(enter_virtual),
        .new_isr(new_isr), .last_isr_jmp(last_isr_jmp), .clear_cause(clear_cause),
        .virtual_mode(vm0), .nmi_n(nmi0), .override_address(ovr0),
        .trap_cause(cause0), .trap_valid(valid0), .trap_pending(pend0)
    );

    virt_mode_ctrl #(.IRQ_TRAP(0)) u_dut_noirq (
        .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .irq_n(irq_n),
        .trap_req(trap_req), .trap_en(trap_en), .enter_virtual(enter_virtual),
        .new_isr(new_isr), .last_isr_jmp(last_isr_jmp), .clear_cause(clear_cause),
        .virtual_mode(vm1), .nmi_n(nmi1), .override_address(ovr1),
        .trap_cause(cause1), .trap_valid(valid1), .trap_pending(pend1)
    );

    virt_mode_ctrl #(.OVR_M1(2)) u_dut_ovr2 (
        .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .irq_n(irq_n),
        .trap_req(trap_req), .trap_en(trap_en), .enter_virtual(enter_virtual),
        .new_isr(new_isr), .last_isr_jmp(last_isr_jmp), .clear_cause(clear_cause),
        .virtual_mode(vm2), .nmi_n(nmi2), .override_address(ovr2),
        .trap_cause(cause2), .trap_valid(valid2), .trap_pending(pend2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m1_cycle(input logic jmp);
        m1_n = 1'b0;
        tick();
        m1_n = 1'b1;
        last_isr_jmp = jmp;
        tick();
        last_isr_jmp = 1'b0;
    endtask

    task automatic enter_all();
        enter_virtual = 1'b1;
        tick();
        enter_virtual = 1'b0;
        m1_cycle(1'b1);
    endtask

    initial begin
        reset_n = 1'b0; m1_n = 1'b1; irq_n = 1'b1; enter_virtual = 1'b0;
        new_isr = 1'b0; last_isr_jmp = 1'b0; clear_cause = 1'b0;
        trap_req = 4'h0; trap_en = 4'h0;
        tick(); tick();
        chk("rst_vm", vm0, 1'b0);
        chk("rst_nmi", nmi0, 1'b1);
        chk("rst_ovr", ovr0, 1'b0);
        chk("rst_cause", cause0, 3'd0);
        chk("rst_valid", valid0, 1'b0);
        chk("rst_pend", pend0, 5'd0);
        reset_n = 1'b1;
        tick();

        // Entry: only the third M1 carries the final return jump; traps ignored while armed
        trap_en = 4'hF; trap_req = 4'b0001;
        enter_virtual = 1'b1; tick(); enter_virtual = 1'b0;
        m1_cycle(1'b0);
        chk("entry_m1a", vm0, 1'b0);
        m1_cycle(1'b0);
        chk("entry_m1b", vm0, 1'b0);
        m1_cycle(1'b1);
        trap_req = 4'h0;
        chk("entry_vm", vm0, 1'b1);
        chk("entry_nmi", nmi0, 1'b1);
        chk("entry_pend", pend0, 5'd0);

        // Single trap, full NMI pulse, ack, one-M1 override
        trap_req = 4'b0100;
        tick();
        trap_req = 4'h0;
        chk("t1_nmi_fall", nmi0, 1'b0);
        chk("t1_cause", cause0, 3'd2);
        chk("t1_valid", valid0, 1'b1);
        chk("t1_pend", pend0, 5'b00100);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_nmi_low", nmi0, 1'b0);
        end
        tick();
        chk("t1_nmi_rise", nmi0, 1'b1);
        chk("t1_vm_wait", vm0, 1'b1);
        new_isr = 1'b1; tick(); new_isr = 1'b0;
        chk("t1_ack_vm", vm0, 1'b0);
        chk("t1_ack_ovr", ovr0, 1'b1);
        m1_n = 1'b0; tick();
        chk("t1_ovr_hold", ovr0, 1'b1);
        m1_n = 1'b1; tick();
        chk("t1_ovr_drop", ovr0, 1'b0);

        // Clear in NATIVE keeps the last cause
        clear_cause = 1'b1; tick(); clear_cause = 1'b0;
        chk("clr0_valid", valid0, 1'b0);
        chk("clr0_pend", pend0, 5'd0);
        chk("clr0_cause", cause0, 3'd2);

        // Priority with IRQ, sticky pending, then clear during NMI
        enter_all();
        chk("pri_vm", vm0, 1'b1);
        trap_req = 4'b1010; irq_n = 1'b0;
        tick();
        trap_req = 4'h0; irq_n = 1'b1;
        chk("pri_cause", cause0, 3'd1);
        chk("pri_pend", pend0, 5'b11010);
        chk("pri_valid", valid0, 1'b1);
        clear_cause = 1'b1; tick(); clear_cause = 1'b0;
        chk("pri_clr_pend", pend0, 5'd0);
        chk("pri_clr_valid", valid0, 1'b0);
        chk("pri_clr_cause", cause0, 3'd1);
        new_isr = 1'b1; tick(); new_isr = 1'b0;
        m1_cycle(1'b0);
        m1_cycle(1'b0);
        chk("pri_native_ovr", ovr2, 1'b0);

        // Masking: trap_en=0 and irq_n=0 for 100 clk
        trap_en = 4'h0;
        enter_all();
        trap_req = 4'hF; irq_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (nmi1 == 1'b0) seen = 1'b1;
        end
        trap_req = 4'h0; irq_n = 1'b1;
        chk("mask_noirq_nmi", seen, 1'b0);
        chk("mask_noirq_vm", vm1, 1'b1);
        chk("mask_noirq_pend", pend1, 5'd0);
        chk("mask_irq_cause", cause0, IRQ_CAUSE);
        chk("mask_irq_pend", pend0, 5'b10000);

        // Reset two clocks after nmi_n falls
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        trap_en = 4'hF;
        enter_all();
        trap_req = 4'b0001;
        tick();
        trap_req = 4'h0;
        chk("rmid_nmi_fall", nmi0, 1'b0);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("rmid_nmi", nmi0, 1'b1);
        chk("rmid_vm", vm0, 1'b0);
        chk("rmid_cause", cause0, 3'd0);
        chk("rmid_valid", valid0, 1'b0);
        chk("rmid_pend", pend0, 5'd0);
        chk("rmid_ovr", ovr0, 1'b0);
        tick();
        reset_n = 1'b1;
        trap_req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (nmi0 == 1'b0) seen = 1'b1;
        end
        trap_req = 4'h0;
        chk("rmid_post_nmi", seen, 1'b0);

        // Early ack on the second NMI clk, OVR_M1=2 build
        enter_all();
        trap_req = 4'b0001;
        tick();
        trap_req = 4'h0;
        chk("early_nmi_e0", nmi2, 1'b0);
        tick();
        chk("early_nmi_e1", nmi2, 1'b0);
        new_isr = 1'b1; tick(); new_isr = 1'b0;
        chk("early_nmi_rise", nmi2, 1'b1);
        chk("early_ovr", ovr2, 1'b1);
        chk("early_vm", vm2, 1'b0);
        m1_n = 1'b0; tick(); m1_n = 1'b1; tick();
        chk("early_ovr_m1a", ovr2, 1'b1);
        chk("early_def_ovr_m1a", ovr0, 1'b0);
        m1_n = 1'b0; tick();
        chk("early_ovr_mid", ovr2, 1'b1);
        m1_n = 1'b1; tick();
        chk("early_ovr_m1b", ovr2, 1'b0);
        trap_req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (nmi2 == 1'b0) seen = 1'b1;
        end
        trap_req = 4'h0;
        chk("early_native", seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
